// File: rtl/aes_round_engine.sv
// Iterative AES round engine: one full round per clock, S-box and round keys supplied externally.
// Supports cipher or inverse cipher (DECRYPT) for AES-128/192/256 (NR = 10/12/14).
module aes_round_engine #(
  parameter int unsigned NR      = 10,
  parameter bit          DECRYPT = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic [127:0] sbox_query,
  input  logic [127:0] sbox_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  localparam logic [3:0] NrL          = 4'(NR);
  localparam logic [3:0] KeyIdxAccept = DECRYPT ? NrL : 4'd0;

  fsm_e          r_fsm, w_fsm_nxt;
  logic [127:0]  r_state, w_state_nxt;
  logic [3:0]    r_rnd, w_rnd_nxt;
  logic          w_accept;
  logic          w_last;
  logic [127:0]  w_sr;
  logic [127:0]  w_ark;
  logic [127:0]  w_round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (row r, column c) sits at bits [127-8*(4c+r) -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Multiply by 9, 11, 13, 14 built from x2/x4/x8 of each byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  assign in_ready   = (r_fsm == StIdle) || ((r_fsm == StDone) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_rnd == NrL);
  assign out_valid  = (r_fsm == StDone);
  assign busy       = (r_fsm == StRound);
  assign out_block  = r_state;

  always_comb begin
    key_idx    = KeyIdxAccept;
    sbox_query = '0;
    if (r_fsm == StRound) begin
      key_idx    = DECRYPT ? (NrL - r_rnd) : r_rnd;
      sbox_query = DECRYPT ? inv_shift_rows(r_state) : r_state;
    end
  end

  always_comb begin
    w_sr        = shift_rows(sbox_result);
    w_ark       = sbox_result ^ round_key;
    w_round_out = '0;
    if (DECRYPT) begin
      w_round_out = w_last ? w_ark : inv_mix_columns(w_ark);
    end else begin
      w_round_out = (w_last ? w_sr : mix_columns(w_sr)) ^ round_key;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    unique case (r_fsm)
      StIdle: begin
        if (w_accept) begin
          w_fsm_nxt   = StRound;
          w_state_nxt = in_block ^ round_key;
          w_rnd_nxt   = 4'd1;
        end
      end
      StRound: begin
        w_state_nxt = w_round_out;
        w_rnd_nxt   = r_rnd + 4'd1;
        if (w_last) begin
          w_fsm_nxt = StDone;
        end
      end
      StDone: begin
        if (w_accept) begin
          w_fsm_nxt   = StRound;
          w_state_nxt = in_block ^ round_key;
          w_rnd_nxt   = 4'd1;
        end else if (out_ready) begin
          w_fsm_nxt = StIdle;
        end
      end
      default: w_fsm_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm   <= StIdle;
      r_state <= '0;
      r_rnd   <= 4'd0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: three instances (AES-128 enc, AES-128 dec, AES-256 enc) driven
// by an S-box/key-schedule environment and checked against FIPS-197 vectors via a scoreboard.
module tb_aes_round_engine;

  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] BPT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BCT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         reset_n;
  logic         in_valid    [3];
  logic         in_ready    [3];
  logic [127:0] in_block    [3];
  logic [3:0]   key_idx     [3];
  logic [127:0] round_key   [3];
  logic [127:0] sbox_query  [3];
  logic [127:0] sbox_result [3];
  logic         out_valid   [3];
  logic         out_ready   [3];
  logic [127:0] out_block   [3];
  logic         busy        [3];
  logic [255:0] key         [3];

  typedef struct {
    int           id;
    logic [127:0] v;
  } sb_t;
  sb_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_round_engine #(.NR(10), .DECRYPT(1'b0)) u_e128 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_block(in_block[0]), .key_idx(key_idx[0]), .round_key(round_key[0]),
    .sbox_query(sbox_query[0]), .sbox_result(sbox_result[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_block(out_block[0]), .busy(busy[0])
  );
  aes_round_engine #(.NR(10), .DECRYPT(1'b1)) u_d128 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_block(in_block[1]), .key_idx(key_idx[1]), .round_key(round_key[1]),
    .sbox_query(sbox_query[1]), .sbox_result(sbox_result[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_block(out_block[1]), .busy(busy[1])
  );
  aes_round_engine #(.NR(14), .DECRYPT(1'b0)) u_e256 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_block(in_block[2]), .key_idx(key_idx[2]), .round_key(round_key[2]),
    .sbox_query(sbox_query[2]), .sbox_result(sbox_result[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_block(out_block[2]), .busy(busy[2])
  );

  // ---------------- environment: GF(2^8) S-box and key schedule ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] gfinv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(a, 8'(y)) == 8'h01) r = 8'(y);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gfinv(x);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gfinv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub16(input logic [127:0] q, input bit inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv ? sbox_inv(q[127-8*i -: 8]) : sbox_fwd(q[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
  endfunction

  function automatic logic [127:0] rk_f(input logic [255:0] k, input int nk,
                                        input logic [3:0] idx);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = k[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int j = 1; j < i / nk; j++) rc = xt(rc);
          t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    if (idx > 4'd14) return '0;
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  assign round_key[0]   = rk_f(key[0], 4, key_idx[0]);
  assign round_key[1]   = rk_f(key[1], 4, key_idx[1]);
  assign round_key[2]   = rk_f(key[2], 8, key_idx[2]);
  assign sbox_result[0] = sub16(sbox_query[0], 1'b0);
  assign sbox_result[1] = sub16(sbox_query[1], 1'b1);
  assign sbox_result[2] = sub16(sbox_query[2], 1'b0);

  // ---------------- checking helpers ----------------
  function automatic int nr_of(input int id);
    return (id == 2) ? 14 : 10;
  endfunction

  function automatic bit dec_of(input int id);
    return id == 1;
  endfunction

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every output handshake pops and compares the oldest expectation.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        for (int i = 0; i < 3; i++) begin
          if (out_valid[i] && out_ready[i]) begin
            if (sb.size() == 0) begin
              chk($sformatf("unexpected_out[%0d]", i), out_block[i], '0);
              if (out_block[i] == '0) begin
                n_fail++;
                $display("FAIL unexpected_out[%0d]: got output, expected none", i);
              end
            end else begin
              e = sb.pop_front();
              chk($sformatf("sb_id[%0d]", i), 128'(i), 128'(e.id));
              chk($sformatf("sb_data[%0d]", i), out_block[i], e.v);
            end
          end
        end
      end
    end
  end

  task automatic issue(input int id, input logic [127:0] blk, input logic [127:0] exp,
                       input bit push);
    int  waited;
    sb_t e;
    waited = 0;
    @(posedge clk);
    #1;
    in_block[id] = blk;
    in_valid[id] = 1'b1;
    if (push) begin
      e.id = id;
      e.v  = exp;
      sb.push_back(e);
    end
    @(negedge clk);
    while (!in_ready[id] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("accept_ready[%0d]", id), 128'(in_ready[id]), 128'(1));
    chk($sformatf("accept_key_idx[%0d]", id), 128'(key_idx[id]),
        dec_of(id) ? 128'(nr_of(id)) : 128'(0));
    @(posedge clk);
    #1;
    in_valid[id] = 1'b0;
  endtask

  // Entered just after the accepting edge; checks per-round outputs and the latency.
  task automatic track(input int id, input bit noise);
    int nr;
    nr = nr_of(id);
    for (int k = 1; k <= nr; k++) begin
      if (noise && k < nr) begin
        in_valid[id] = 1'b1;
        in_block[id] = 128'h0badf00d_0badf00d_0badf00d_00000000 ^ 128'(k);
      end else begin
        in_valid[id] = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("round_busy[%0d] k=%0d", id, k), 128'(busy[id]), 128'(1));
      chk($sformatf("round_out_valid[%0d] k=%0d", id, k), 128'(out_valid[id]), 128'(0));
      chk($sformatf("round_in_ready[%0d] k=%0d", id, k), 128'(in_ready[id]), 128'(0));
      chk($sformatf("round_key_idx[%0d] k=%0d", id, k), 128'(key_idx[id]),
          dec_of(id) ? 128'(nr - k) : 128'(k));
      @(posedge clk);
      #1;
    end
    in_valid[id] = 1'b0;
    @(negedge clk);
    chk($sformatf("done_out_valid[%0d]", id), 128'(out_valid[id]), 128'(1));
    chk($sformatf("done_busy[%0d]", id), 128'(busy[id]), 128'(0));
    chk($sformatf("done_sbox_query[%0d]", id), sbox_query[id], '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov_seen;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_block[i]  = '0;
      out_ready[i] = 1'b1;
    end
    key[0] = {K128, 128'h0};
    key[1] = {K128, 128'h0};
    key[2] = K256;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
      chk($sformatf("rst_busy[%0d]", i), 128'(busy[i]), 128'(0));
      chk($sformatf("rst_in_ready[%0d]", i), 128'(in_ready[i]), 128'(1));
      chk($sformatf("rst_out_block[%0d]", i), out_block[i], '0);
      chk($sformatf("rst_key_idx[%0d]", i), 128'(key_idx[i]),
          dec_of(i) ? 128'(nr_of(i)) : 128'(0));
      chk($sformatf("rst_sbox_query[%0d]", i), sbox_query[i], '0);
    end
    reset_n = 1'b1;

    // FIPS-197 C.1 cipher and inverse, B inverse, C.3 cipher with ignored in_valid noise.
    issue(0, PT, CT128, 1'b1);
    track(0, 1'b0);
    issue(1, CT128, PT, 1'b1);
    track(1, 1'b0);
    @(posedge clk);
    #1;
    key[1] = {KB, 128'h0};
    issue(1, BCT, BPT, 1'b1);
    track(1, 1'b0);
    issue(2, PT, CT256, 1'b1);
    track(2, 1'b1);

    // Output back-pressure, ignored input while stalled, then same-cycle accept in DONE.
    out_ready[0] = 1'b0;
    issue(0, PT, CT128, 1'b1);
    track(0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid[0] = 1'b1;
      in_block[0] = BPT;
      @(negedge clk);
      chk($sformatf("stall_out_valid c=%0d", i), 128'(out_valid[0]), 128'(1));
      chk($sformatf("stall_out_block c=%0d", i), out_block[0], CT128);
      chk($sformatf("stall_in_ready c=%0d", i), 128'(in_ready[0]), 128'(0));
      chk($sformatf("stall_busy c=%0d", i), 128'(busy[0]), 128'(0));
    end
    @(posedge clk);
    #1;
    key[0]       = {KB, 128'h0};
    out_ready[0] = 1'b1;
    begin
      sb_t e;
      e.id = 0;
      e.v  = BCT;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("b2b_in_ready", 128'(in_ready[0]), 128'(1));
    chk("b2b_key_idx", 128'(key_idx[0]), 128'(0));
    @(posedge clk);
    #1;
    track(0, 1'b0);

    // Reset in the middle of round 5 discards the block.
    @(posedge clk);
    #1;
    key[0] = {K128, 128'h0};
    issue(0, PT, CT128, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
    chk("mid_rst_busy", 128'(busy[0]), 128'(0));
    chk("mid_rst_out_block", out_block[0], '0);
    chk("mid_rst_key_idx", 128'(key_idx[0]), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    ov_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid[0]) ov_seen++;
    end
    chk("post_rst_no_out_valid", 128'(ov_seen), 128'(0));
    issue(0, PT, CT128, 1'b1);
    track(0, 1'b0);

    @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
